// File: rtl/bram_data_loader_pkg.sv
// Shared definitions for the BRAM song-data loader: FSM encodings and song index width.
package bram_data_loader_pkg;

  localparam int unsigned SongIdxW = 8;
  localparam int unsigned StateW   = 2;

  localparam logic [StateW-1:0] StIdle    = 2'd0;
  localparam logic [StateW-1:0] StRestart = 2'd1;
  localparam logic [StateW-1:0] StReceive = 2'd2;
  localparam logic [StateW-1:0] StDone    = 2'd3;

  typedef logic [SongIdxW-1:0] song_idx_t;

endpackage

// File: rtl/bram_data_loader_if.sv
// Bundles the BRAM write port, core start/done strobes and the CPU byte channel of the loader.
interface bram_data_loader_if
  import bram_data_loader_pkg::*;
#(
  parameter int unsigned addr_width         = 13,
  parameter int unsigned data_width_in_byte = 3
);

  logic [addr_width-1:0]           bram_addr_w;
  logic [8*data_width_in_byte-1:0] bram_data_in;
  logic                            bram_en_w;
  logic                            sig_on;
  logic                            sig_done;
  logic                            restart;
  song_idx_t                       init_index;
  logic [7:0]                      init_aux_info;
  logic                            request_data;
  logic                            data_ready;
  logic [7:0]                      cpu_data_in;
  logic                            transmit_finished;
  song_idx_t                       song_selection;

  // Loader side.
  modport master (
    output bram_addr_w, bram_data_in, bram_en_w, sig_done, restart,
           init_index, init_aux_info, request_data,
    input  sig_on, data_ready, cpu_data_in, transmit_finished, song_selection
  );

  // Environment side (core sequencer, CPU channel and BRAM).
  modport slave (
    input  bram_addr_w, bram_data_in, bram_en_w, sig_done, restart,
           init_index, init_aux_info, request_data,
    output sig_on, data_ready, cpu_data_in, transmit_finished, song_selection
  );

endinterface

// File: rtl/bram_data_loader.sv
// Streams one song from the CPU byte channel into BRAM, packing data_width_in_byte bytes per word.
module bram_data_loader
  import bram_data_loader_pkg::*;
#(
  parameter int unsigned addr_width           = 13,
  parameter int unsigned data_width_in_byte   = 3,
  parameter logic [7:0]  static_init_aux_info = 8'h00,
  parameter int unsigned restarting_timeout   = 5
) (
  input  logic               CLK,
  input  logic               RESET_L,
  bram_data_loader_if.master bus
);

  localparam int unsigned DataW    = 8 * data_width_in_byte;
  localparam int unsigned ByteCntW = (data_width_in_byte > 1) ? $clog2(data_width_in_byte) : 1;
  localparam int unsigned TmoCntW  = $clog2(restarting_timeout + 1);

  localparam logic [ByteCntW-1:0] LastByte = ByteCntW'(data_width_in_byte - 1);
  localparam logic [TmoCntW-1:0]  LastTmo  = TmoCntW'(restarting_timeout - 1);

  logic [StateW-1:0]     state_q, state_d;
  logic [TmoCntW-1:0]    tmo_q, tmo_d;
  logic [ByteCntW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [DataW-1:0]      word_q, word_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [addr_width-1:0] bram_addr_q, bram_addr_d;
  logic [DataW-1:0]      bram_data_q, bram_data_d;
  logic                  bram_en_q, bram_en_d;
  song_idx_t             init_index_q, init_index_d;

  // Word with the incoming byte appended; older bytes move toward the MSBs (big-endian).
  logic [DataW-1:0]      word_shift;

  if (data_width_in_byte > 1) begin : g_shift_multi
    assign word_shift = {word_q[DataW-9:0], bus.cpu_data_in};
  end else begin : g_shift_single
    assign word_shift = bus.cpu_data_in;
  end

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    addr_d       = addr_q;
    bram_addr_d  = bram_addr_q;
    bram_data_d  = bram_data_q;
    bram_en_d    = 1'b0;
    init_index_d = init_index_q;

    case (state_q)
      StIdle: begin
        if (bus.sig_on) begin
          state_d      = StRestart;
          init_index_d = bus.song_selection;
          addr_d       = '0;
          byte_cnt_d   = '0;
          tmo_d        = '0;
        end
      end

      StRestart: begin
        if (tmo_q == LastTmo) begin
          state_d = StReceive;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StReceive: begin
        // A byte arriving with transmit_finished is still consumed before leaving.
        if (bus.data_ready) begin
          word_d = word_shift;
          if (byte_cnt_q == LastByte) begin
            byte_cnt_d  = '0;
            bram_en_d   = 1'b1;
            bram_data_d = word_shift;
            bram_addr_d = addr_q;
            addr_d      = addr_q + 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
        if (bus.transmit_finished) begin
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET_L) begin
      state_q      <= StIdle;
      tmo_q        <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      addr_q       <= '0;
      bram_addr_q  <= '0;
      bram_data_q  <= '0;
      bram_en_q    <= 1'b0;
      init_index_q <= '0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      bram_addr_q  <= bram_addr_d;
      bram_data_q  <= bram_data_d;
      bram_en_q    <= bram_en_d;
      init_index_q <= init_index_d;
    end
  end

  assign bus.bram_addr_w   = bram_addr_q;
  assign bus.bram_data_in  = bram_data_q;
  assign bus.bram_en_w     = bram_en_q;
  assign bus.init_index    = init_index_q;
  assign bus.init_aux_info = static_init_aux_info;
  assign bus.restart       = (state_q == StRestart);
  assign bus.request_data  = (state_q == StReceive);
  assign bus.sig_done      = (state_q == StDone);

endmodule

// File: tb/tb_bram_data_loader.sv
// Directed bench for bram_data_loader: restart timing, byte packing, partial words, reset abort.
module tb_bram_data_loader;

  localparam int unsigned AW  = 13;
  localparam int unsigned DWB = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bram_data_loader_if #(.addr_width(AW), .data_width_in_byte(DWB)) bus ();

  bram_data_loader #(
    .addr_width          (AW),
    .data_width_in_byte  (DWB),
    .static_init_aux_info(8'h00),
    .restarting_timeout  (5)
  ) dut (
    .CLK    (clk),
    .RESET_L(rst),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0]    b;
    int unsigned   gap;
    logic          en;
    logic [AW-1:0] addr;
    logic [23:0]   data;
  } vec_t;

  vec_t tbl[12];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.data_ready  = 1'b1;
    bus.cpu_data_in = b;
    tick();
    bus.data_ready  = 1'b0;
    bus.cpu_data_in = 8'h00;
  endtask

  // Pulses sig_on, counts restart cycles until request_data rises (bounded).
  task automatic start_song(input logic [7:0] sel);
    int n;
    n = 0;
    bus.song_selection = sel;
    bus.sig_on         = 1'b1;
    tick();
    bus.sig_on         = 1'b0;
    bus.song_selection = ~sel;
    for (int i = 0; i < 20 && !bus.request_data; i++) begin
      if (bus.restart) n++;
      tick();
    end
    chk("restart_cycles", n, 5);
    chk("request_data_up", bus.request_data, 1);
    chk("restart_low_in_receive", bus.restart, 0);
    chk("init_index", bus.init_index, sel);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 12; i++) begin
      tbl[i].b    = 8'(i + 1);
      tbl[i].gap  = i + 1;
      tbl[i].en   = 1'b0;
      tbl[i].addr = '0;
      tbl[i].data = '0;
    end
    tbl[2].en  = 1'b1; tbl[2].addr  = 13'd0; tbl[2].data  = 24'h010203;
    tbl[5].en  = 1'b1; tbl[5].addr  = 13'd1; tbl[5].data  = 24'h040506;
    tbl[8].en  = 1'b1; tbl[8].addr  = 13'd2; tbl[8].data  = 24'h070809;
    tbl[11].en = 1'b1; tbl[11].addr = 13'd3; tbl[11].data = 24'h0A0B0C;

    rst                   = 1'b1;
    bus.sig_on            = 1'b0;
    bus.data_ready        = 1'b0;
    bus.cpu_data_in       = 8'h00;
    bus.transmit_finished = 1'b0;
    bus.song_selection    = 8'h00;

    // Reset state
    repeat (10) tick();
    chk("rst_bram_en", bus.bram_en_w, 0);
    chk("rst_bram_addr", bus.bram_addr_w, 0);
    chk("rst_bram_data", bus.bram_data_in, 0);
    chk("rst_sig_done", bus.sig_done, 0);
    chk("rst_restart", bus.restart, 0);
    chk("rst_init_index", bus.init_index, 0);
    chk("rst_aux_info", bus.init_aux_info, 8'h00);
    chk("rst_request_data", bus.request_data, 0);
    rst = 1'b0;
    tick();
    chk("idle_restart", bus.restart, 0);

    // Twelve bytes with growing gaps
    start_song(8'h00);
    for (int i = 0; i < 12; i++) begin
      send_byte(tbl[i].b);
      chk($sformatf("wr_en[%0d]", i), bus.bram_en_w, tbl[i].en);
      if (tbl[i].en) begin
        chk($sformatf("wr_addr[%0d]", i), bus.bram_addr_w, tbl[i].addr);
        chk($sformatf("wr_data[%0d]", i), bus.bram_data_in, tbl[i].data);
      end
      for (int g = 0; g < int'(tbl[i].gap); g++) begin
        tick();
        chk($sformatf("gap_en[%0d]", i), bus.bram_en_w, 0);
      end
    end
    bus.transmit_finished = 1'b1;
    tick();
    bus.transmit_finished = 1'b0;
    chk("done_pulse", bus.sig_done, 1);
    chk("done_request_low", bus.request_data, 0);
    chk("done_restart_low", bus.restart, 0);
    chk("hold_addr", bus.bram_addr_w, 3);
    chk("hold_data", bus.bram_data_in, 24'h0A0B0C);
    tick();
    chk("done_one_cycle", bus.sig_done, 0);
    chk("idle_request_low", bus.request_data, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_restart_after_done", bus.restart, 0);
    end
    bus.sig_on = 1'b1;
    tick();
    bus.sig_on = 1'b0;
    chk("restart_again", bus.restart, 1);
    for (int i = 0; i < 4; i++) tick();
    bus.sig_on = 1'b1;
    tick();
    bus.sig_on = 1'b0;
    chk("sig_on_ignored_in_receive", bus.restart, 0);
    bus.transmit_finished = 1'b1;
    tick();
    bus.transmit_finished = 1'b0;
    chk("empty_done", bus.sig_done, 1);
    tick();

    // Partial trailing word is dropped
    start_song(8'h2A);
    send_byte(8'h01);
    tick();
    send_byte(8'h02);
    tick();
    send_byte(8'h03);
    chk("p_wr_en", bus.bram_en_w, 1);
    chk("p_wr_addr", bus.bram_addr_w, 0);
    chk("p_wr_data", bus.bram_data_in, 24'h010203);
    tick();
    send_byte(8'h04);
    chk("p_byte4_no_wr", bus.bram_en_w, 0);
    bus.transmit_finished = 1'b1;
    tick();
    bus.transmit_finished = 1'b0;
    chk("p_done", bus.sig_done, 1);
    chk("p_partial_dropped", bus.bram_en_w, 0);
    chk("p_data_hold", bus.bram_data_in, 24'h010203);
    tick();
    chk("p_done_one_cycle", bus.sig_done, 0);
    chk("p_init_index_held", bus.init_index, 8'h2A);

    // Back-to-back bytes, last one together with transmit_finished
    start_song(8'h07);
    for (int i = 0; i < 6; i++) begin
      bus.data_ready        = 1'b1;
      bus.cpu_data_in       = 8'(8'h11 + i);
      bus.transmit_finished = (i == 5);
      tick();
      chk($sformatf("b2b_en[%0d]", i), bus.bram_en_w, (i == 2 || i == 5));
      if (i == 2) begin
        chk("b2b_addr0", bus.bram_addr_w, 0);
        chk("b2b_data0", bus.bram_data_in, 24'h111213);
      end
      if (i == 5) begin
        chk("b2b_addr1", bus.bram_addr_w, 1);
        chk("b2b_data1", bus.bram_data_in, 24'h141516);
        chk("b2b_done", bus.sig_done, 1);
      end
    end
    bus.data_ready        = 1'b0;
    bus.transmit_finished = 1'b0;
    tick();
    chk("b2b_done_one_cycle", bus.sig_done, 0);
    chk("b2b_en_low", bus.bram_en_w, 0);

    // Reset in the middle of RECEIVE
    start_song(8'h55);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst             = 1'b1;
    bus.data_ready  = 1'b1;
    bus.cpu_data_in = 8'hCC;
    tick();
    rst             = 1'b0;
    bus.data_ready  = 1'b0;
    chk("mid_rst_request", bus.request_data, 0);
    chk("mid_rst_done", bus.sig_done, 0);
    chk("mid_rst_en", bus.bram_en_w, 0);
    chk("mid_rst_restart", bus.restart, 0);
    chk("mid_rst_index", bus.init_index, 0);
    chk("mid_rst_addr", bus.bram_addr_w, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_done", bus.sig_done, 0);
      chk("post_rst_idle", bus.request_data, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
